// File: rtl/mult3_pkg.sv
// Shared constants and types for the shared 3-bit multiplier arbiter.
package mult3_pkg;

    localparam int MULT_OP_W = 3;
    localparam int MULT_P_W  = 6;
    localparam int CNT_W     = 16;

    typedef logic [MULT_OP_W-1:0] mult_op_t;
    typedef logic [MULT_P_W-1:0]  mult_prod_t;

    // The response register is either holding a result or not.
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } rsp_state_t;

endpackage

// File: rtl/multiplier_3bit.sv
// Purely combinational unsigned 3x3 multiplier; the full 6-bit product is kept.
module multiplier_3bit
    import mult3_pkg::*;
(
    input  logic [MULT_OP_W-1:0] a,
    input  logic [MULT_OP_W-1:0] b,
    output logic [MULT_P_W-1:0]  p
);

    assign p = MULT_P_W'(a) * MULT_P_W'(b);

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant: the first asserted request at or after ptr,
// wrapping at N_REQ-1, so a non-power-of-two N_REQ never yields a bogus index.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  grant_idx
);

    localparam int CW = ID_W + 1;

    logic [CW-1:0] cand;
    logic          found;

    // Scan from ptr upward modulo N_REQ and keep the first valid requester.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = {1'b0, ptr} + CW'(k);
            if (cand >= CW'(N_REQ)) begin
                cand = cand - CW'(N_REQ);
            end
            if (!found && req[cand[ID_W-1:0]]) begin
                found                  = 1'b1;
                grant_idx              = cand[ID_W-1:0];
                grant[cand[ID_W-1:0]] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mult3_arbiter.sv
// N_REQ requesters share one combinational multiplier through a round-robin
// arbiter; each product is registered with its owner's ID in a single-entry
// response register that supports drain-and-refill in the same cycle.
module mult3_arbiter
    import mult3_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [N_REQ-1:0]            req_valid,
    input  logic [MULT_OP_W*N_REQ-1:0]  req_a,
    input  logic [MULT_OP_W*N_REQ-1:0]  req_b,
    output logic [N_REQ-1:0]            req_ready,
    output logic                        rsp_valid,
    output logic [ID_W-1:0]             rsp_id,
    output logic [MULT_P_W-1:0]         rsp_p,
    input  logic                        rsp_ready,
    output logic [CNT_W-1:0]            txn_count
);

    rsp_state_t           state;
    rsp_state_t           state_next;
    logic                 run;
    logic                 can_accept;
    logic                 transfer;
    logic [ID_W-1:0]      ptr;
    logic [ID_W-1:0]      ptr_next;
    logic [ID_W-1:0]      grant_idx;
    logic [N_REQ-1:0]     grant;
    logic [MULT_OP_W-1:0] sel_a;
    logic [MULT_OP_W-1:0] sel_b;
    logic [MULT_P_W-1:0]  product;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_arb (
        .req       (req_valid),
        .ptr       (ptr),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    multiplier_3bit u_mult (
        .a (sel_a),
        .b (sel_b),
        .p (product)
    );

    assign rsp_valid  = (state == ST_FULL);
    assign can_accept = !rsp_valid || rsp_ready;

    // run stays low through reset and the edge on which reset releases, so
    // no request can be accepted until the first clean edge afterwards.
    assign req_ready  = grant & {N_REQ{can_accept & run}};
    assign transfer   = |(req_valid & req_ready);

    assign sel_a = req_a[int'(grant_idx)*MULT_OP_W +: MULT_OP_W];
    assign sel_b = req_b[int'(grant_idx)*MULT_OP_W +: MULT_OP_W];

    assign ptr_next = (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + ID_W'(1);

    // Arm the accept path one edge after reset is released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run <= 1'b0;
        end else begin
            run <= 1'b1;
        end
    end

    // Response-register occupancy state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // A transfer always fills the register; a drain empties it only when
    // nothing new arrives in the same cycle.
    always_comb begin
        state_next = state;
        case (state)
            ST_EMPTY: begin
                if (transfer) begin
                    state_next = ST_FULL;
                end
            end
            ST_FULL: begin
                if (!transfer && rsp_ready) begin
                    state_next = ST_EMPTY;
                end
            end
            default: state_next = ST_EMPTY;
        endcase
    end

    // Capture the winner's product and ID, advance the pointer and count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_id    <= '0;
            rsp_p     <= '0;
            ptr       <= '0;
            txn_count <= '0;
        end else if (transfer) begin
            rsp_id    <= grant_idx;
            rsp_p     <= product;
            ptr       <= ptr_next;
            txn_count <= txn_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_mult3_arbiter.sv
// Scoreboard bench for mult3_arbiter (N_REQ=4) plus a directed check of an
// N_REQ=3 instance for pointer wrap and skipping of idle requesters.
module tb_mult3_arbiter;

    typedef struct packed {
        logic [1:0] id;
        logic [5:0] p;
    } sb_item_t;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [11:0] req_a;
    logic [11:0] req_b;
    logic [3:0]  req_ready;
    logic        rsp_valid;
    logic [1:0]  rsp_id;
    logic [5:0]  rsp_p;
    logic        rsp_ready;
    logic [15:0] txn_count;

    logic [2:0]  v3;
    logic [8:0]  a3;
    logic [8:0]  b3;
    logic [2:0]  req_ready3;
    logic        rsp_valid3;
    logic [1:0]  rsp_id3;
    logic [5:0]  rsp_p3;
    logic        rsp_ready3;
    logic [15:0] txn_count3;

    int          check_count = 0;
    int          error_count = 0;
    sb_item_t    sb_q[$];
    logic [3:0]  last_accept = '0;
    logic [1:0]  m_ptr = '0;
    logic        m_full = 1'b0;
    logic        m_run = 1'b0;
    logic [15:0] m_count = '0;
    logic        rand_ready = 1'b0;

    mult3_arbiter #(.N_REQ(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_p     (rsp_p),
        .rsp_ready (rsp_ready),
        .txn_count (txn_count)
    );

    mult3_arbiter #(.N_REQ(3)) dut3 (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (v3),
        .req_a     (a3),
        .req_b     (b3),
        .req_ready (req_ready3),
        .rsp_valid (rsp_valid3),
        .rsp_id    (rsp_id3),
        .rsp_p     (rsp_p3),
        .rsp_ready (rsp_ready3),
        .txn_count (txn_count3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got %0d, wanted %0d (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    // Hold one requester's operands until the model says it was accepted.
    task automatic applyStimulus(input int idx, input logic [2:0] a, input logic [2:0] b);
        int waited = 0;
        @(negedge clk);
        req_a[3*idx +: 3] = a;
        req_b[3*idx +: 3] = b;
        req_valid[idx]    = 1'b1;
        do begin
            @(negedge clk);
            waited++;
        end while (!last_accept[idx] && waited < 100);
        checkOutput("accept_wait", 32'(last_accept[idx]), 32'd1);
        req_valid[idx] = 1'b0;
    endtask

    // Requesters that were just accepted present fresh operands.
    task automatic refreshOperands();
        for (int i = 0; i < 4; i++) begin
            if (last_accept[i]) begin
                req_a[3*i +: 3] = 3'($urandom_range(0, 7));
                req_b[3*i +: 3] = 3'($urandom_range(0, 7));
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (rand_ready) begin
                rsp_ready = ($urandom_range(0, 3) != 0);
            end
        end
    end

    // Reference model and scoreboard, evaluated just before every rising edge.
    initial begin
        int         win;
        logic [3:0] exp_ready;
        sb_item_t   item;
        sb_item_t   got;
        forever begin
            @(negedge clk);
            #4;
            if (!rst_n) begin
                checkOutput("rst_ready", 32'(req_ready), 32'd0);
                checkOutput("rst_valid", 32'(rsp_valid), 32'd0);
                m_ptr       = '0;
                m_full      = 1'b0;
                m_run       = 1'b0;
                m_count     = '0;
                last_accept = '0;
                sb_q.delete();
            end else begin
                win       = -1;
                exp_ready = '0;
                if (m_run && (!m_full || rsp_ready)) begin
                    for (int k = 0; k < 4; k++) begin
                        if (win < 0 && req_valid[(int'(m_ptr) + k) % 4]) begin
                            win = (int'(m_ptr) + k) % 4;
                        end
                    end
                end
                if (win >= 0) begin
                    exp_ready[win] = 1'b1;
                end
                checkOutput("req_ready", 32'(req_ready), 32'(exp_ready));
                checkOutput("rsp_valid", 32'(rsp_valid), 32'(m_full));
                checkOutput("txn_count", 32'(txn_count), 32'(m_count));
                if (m_full && rsp_ready) begin
                    if (sb_q.size() == 0) begin
                        checkOutput("sb_underflow", 32'(sb_q.size()), 32'd1);
                    end else begin
                        got = sb_q.pop_front();
                        checkOutput("rsp_id", 32'(rsp_id), 32'(got.id));
                        checkOutput("rsp_p", 32'(rsp_p), 32'(got.p));
                    end
                end
                last_accept = exp_ready;
                if (win >= 0) begin
                    item.id = 2'(win);
                    item.p  = 6'(int'(req_a[3*win +: 3]) * int'(req_b[3*win +: 3]));
                    sb_q.push_back(item);
                    m_ptr   = 2'((win + 1) % 4);
                    m_count = m_count + 16'd1;
                    m_full  = 1'b1;
                end else if (m_full && rsp_ready) begin
                    m_full = 1'b0;
                end
                m_run = 1'b1;
            end
        end
    end

    initial begin
        int  reached;
        rst_n      = 1'b0;
        req_valid  = 4'b0100;
        req_a      = 12'h0;
        req_b      = 12'h0;
        req_a[8:6] = 3'd7;
        req_b[8:6] = 3'd7;
        rsp_ready  = 1'b1;
        v3         = 3'b000;
        a3         = {3'd7, 3'd0, 3'd6};
        b3         = {3'd5, 3'd0, 3'd4};
        rsp_ready3 = 1'b1;

        // Reset values with a request already pending.
        #3;
        checkOutput("reset_valid", 32'(rsp_valid), 32'd0);
        checkOutput("reset_p", 32'(rsp_p), 32'd0);
        checkOutput("reset_id", 32'(rsp_id), 32'd0);
        checkOutput("reset_count", 32'(txn_count), 32'd0);
        checkOutput("reset_ready", 32'(req_ready), 32'd0);

        // Single request from requester 2: 7*7, nothing accepted on release.
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #2;
        checkOutput("release_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        #2;
        checkOutput("single_ready", 32'(req_ready), 32'b0100);
        @(negedge clk);
        req_valid[2] = 1'b0;
        #2;
        checkOutput("single_p", 32'(rsp_p), 32'd49);
        checkOutput("single_id", 32'(rsp_id), 32'd2);
        checkOutput("single_count", 32'(txn_count), 32'd1);

        // Pointer is now 3: with 0 and 3 requesting, 3 wins first.
        req_a[2:0]  = 3'd1;
        req_b[2:0]  = 3'd1;
        req_a[11:9] = 3'd2;
        req_b[11:9] = 3'd3;
        req_valid   = 4'b1001;
        #1;
        checkOutput("ptr3_grant", 32'(req_ready), 32'b1000);
        @(negedge clk);
        req_valid[3] = 1'b0;
        #2;
        checkOutput("ptr0_grant", 32'(req_ready), 32'b0001);
        @(negedge clk);
        req_valid[0] = 1'b0;
        rsp_ready    = 1'b0;

        // Reset while a result is held: it must disappear immediately.
        @(negedge clk);
        #2;
        rst_n     = 1'b0;
        req_valid = 4'b1111;
        req_a     = 12'($urandom);
        req_b     = 12'($urandom);
        #1;
        checkOutput("midrst_valid", 32'(rsp_valid), 32'd0);
        checkOutput("midrst_p", 32'(rsp_p), 32'd0);
        checkOutput("midrst_count", 32'(txn_count), 32'd0);
        checkOutput("midrst_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        #2;
        checkOutput("midrel_ready", 32'(req_ready), 32'd0);

        // Round-robin with all four requesting continuously.
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            refreshOperands();
            #2;
            checkOutput("rr_grant", 32'(req_ready), 32'd1 << (n % 4));
            if (n > 0) begin
                checkOutput("rr_valid", 32'(rsp_valid), 32'd1);
            end
        end
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        rsp_ready = 1'b0;

        // Back-pressure: 5*3 held for five cycles, then drain and refill.
        applyStimulus(1, 3'd5, 3'd3);
        req_a[2:0]   = 3'd2;
        req_b[2:0]   = 3'd6;
        req_valid[0] = 1'b1;
        for (int s = 0; s < 5; s++) begin
            #2;
            checkOutput("stall_p", 32'(rsp_p), 32'd15);
            checkOutput("stall_id", 32'(rsp_id), 32'd1);
            checkOutput("stall_valid", 32'(rsp_valid), 32'd1);
            checkOutput("stall_ready", 32'(req_ready), 32'd0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        #2;
        checkOutput("refill_ready", 32'(req_ready), 32'b0001);
        @(negedge clk);
        #2;
        checkOutput("refill_p", 32'(rsp_p), 32'd12);
        checkOutput("refill_id", 32'(rsp_id), 32'd0);
        checkOutput("refill_valid", 32'(rsp_valid), 32'd1);
        @(negedge clk);
        req_valid[0] = 1'b0;

        // All 64 operand pairs through requester 1 with random back-pressure.
        rand_ready = 1'b1;
        for (int a = 0; a < 8; a++) begin
            for (int b = 0; b < 8; b++) begin
                applyStimulus(1, 3'(a), 3'(b));
            end
        end
        rand_ready = 1'b0;
        @(negedge clk);
        rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);

        // N_REQ=3 instance: requesters 0 and 2 alternate, 1 is skipped.
        @(negedge clk);
        v3 = 3'b101;
        for (int n = 0; n < 8; n++) begin
            #2;
            checkOutput("n3_grant", 32'(req_ready3), (n % 2 == 0) ? 32'b001 : 32'b100);
            checkOutput("n3_valid", 32'(rsp_valid3), (n > 0) ? 32'd1 : 32'd0);
            if (n > 0) begin
                checkOutput("n3_id", 32'(rsp_id3), (n % 2 == 1) ? 32'd0 : 32'd2);
                checkOutput("n3_p", 32'(rsp_p3), (n % 2 == 1) ? 32'd24 : 32'd35);
            end
            @(negedge clk);
        end
        v3 = 3'b000;
        #2;
        checkOutput("n3_count", 32'(txn_count3), 32'd8);

        // Run the counter up to 65535 and across the wrap.
        req_a     = 12'($urandom);
        req_b     = 12'($urandom);
        req_valid = 4'b1111;
        reached   = 0;
        for (int c = 0; c < 70000; c++) begin
            @(negedge clk);
            refreshOperands();
            if (m_count == 16'hFFFF) begin
                reached = 1;
                break;
            end
        end
        checkOutput("wrap_reached", 32'(m_count), 32'hFFFF);
        #2;
        checkOutput("count_max", 32'(txn_count), 32'hFFFF);
        if (reached == 1) begin
            @(negedge clk);
            #2;
            checkOutput("count_wrap", 32'(txn_count), 32'd0);
        end
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("sb_left", 32'(sb_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", error_count, check_count);
        $finish;
    end

endmodule

// File: doc/mult3_arbiter.md
# mult3_arbiter

- Shares one combinational `multiplier_3bit` instance among `N_REQ` requesters.
- Each requester presents 3-bit operands on a valid/ready handshake.
- A round-robin arbiter grants one requester per cycle and feeds the shared multiplier.
- The 6-bit product is registered with the winner's ID and returned on a single response channel under back-pressure.

## Interface
Parameters:
- `N_REQ`, default 4: number of requesters (2..8).
- `ID_W`, default `$clog2(N_REQ)`: width of the response ID.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `req_valid`  in  `N_REQ`: per-requester operand valid.
- `req_a`  in  `3*N_REQ`: operand A; requester i is on bits [3i+2:3i].
- `req_b`  in  `3*N_REQ`: operand B; same packing as `req_a`.
- `req_ready`  out  `N_REQ`: per-requester accept; at most one bit high.
- `rsp_valid`  out  1: product register holds a result.
- `rsp_id`  out  `ID_W`: index of the requester that owns `rsp_p`.
- `rsp_p`  out  6: product A*B.
- `rsp_ready`  in  1: consumer accepts the response.
- `txn_count`  out  16: number of accepted requests; wraps modulo 2^16.

## Operation
- **Output register.** A single entry holding `rsp_valid`, `rsp_id` and `rsp_p`.
- **Capacity.** `can_accept = !rsp_valid | rsp_ready`.
- **Grant selection.**
  - Round-robin pointer `ptr` (width `ID_W`).
  - The grant is the first `req_valid[i]` scanning i = ptr, ptr+1, … modulo `N_REQ`.
  - `req_ready[i] = grant[i] & can_accept`.
  - A transfer occurs when `req_valid[i] & req_ready[i]`.
- **On a transfer:**
  - `rsp_p` ← `multiplier_3bit(req_a[i], req_b[i])`.
  - `rsp_id` ← i.
  - `rsp_valid` ← 1.
  - `ptr` ← (i+1) mod `N_REQ`.
  - `txn_count` increments.
- **On `rsp_valid & rsp_ready` with no transfer:** `rsp_valid` ← 0. `rsp_id` and `rsp_p` hold their old values.
- **Drain and accept in the same cycle:** the new result overwrites the old one. There are no bubbles, so throughput is one per cycle.
- **No valid request:** `ptr` holds and no grant is issued.
- **Requester rule:** requesters must keep A/B stable and `req_valid` high until accepted. `req_valid` must not depend on `req_ready`.
- **Non-power-of-two `N_REQ`:** the pointer wraps at `N_REQ-1` → 0 and never takes an index ≥ `N_REQ`.
- **Control FSM.** Derived from `rsp_valid`: EMPTY (`rsp_valid`=0) and FULL (`rsp_valid`=1).
  - EMPTY → FULL on a transfer.
  - FULL → EMPTY on a drain without a transfer.
  - FULL → FULL on a stall, or on a drain with a transfer.
- **Arithmetic.** Unsigned throughout. The product range is 0..49 and is never truncated.

## Timing
- **Reset values (asynchronous assertion):**
  - `rsp_valid`=0, `rsp_id`=0, `rsp_p`=0.
  - `ptr`=0, `txn_count`=0.
- **Reset release:** synchronous to `clk`. No transfer occurs in the cycle in which `rst_n` rises.
- **Outputs during and after reset:** `req_ready` is all zeros while `rst_n`=0. From the first active edge after reset it is combinational from `req_valid`, `ptr`, `rsp_valid` and `rsp_ready`.
- **Latency:** accepted at edge k; `rsp_valid` and the result are visible after edge k and remain stable until the handshake.
- **Reset mid-operation:** any held result is discarded and no response is emitted for it.
- **Stall behaviour:**
  - While `rsp_valid=1` and `rsp_ready=0`, all `req_ready` bits are 0.
  - `ptr` does not change.
  - The response outputs are stable.

## Structure
- Package `mult3_pkg` holds:
  - Constants `MULT_OP_W=3`, `MULT_P_W=6`, `CNT_W=16`.
  - Typedef `mult_op_t` (`logic [2:0]`) and typedef `mult_prod_t` (`logic [5:0]`).
- Sub-module `rr_arbiter`, parameterised by `N_REQ`.
  - Inputs: `req` vector and `ptr`.
  - Outputs: one-hot `grant` and encoded `grant_idx`.
  - Purely combinational.
- The top instantiates `rr_arbiter` and one `multiplier_3bit`. The operand mux is driven by `grant_idx`.
- The output register, pointer and counter live in the top.

## Test plan
- **Reset:** assert `rst_n`=0 mid-transfer.
  - Expect `rsp_valid`=0, `rsp_p`=0, `txn_count`=0 immediately.
  - Expect `req_ready`=0 until the first edge after release.
- **Single request:** requester 2 presents A=7, B=7 with `rsp_ready`=1.
  - Expect one cycle later `rsp_p`=49, `rsp_id`=2, `txn_count`=1, `ptr`=3.
- **Round-robin fairness:** all 4 requesters valid continuously with `rsp_ready`=1.
  - Expect grants in order 0,1,2,3,0,… and `rsp_valid` high every cycle after the first.
- **Back-pressure:** `rsp_ready`=0 for 5 cycles with a result held (A=5, B=3).
  - Expect `rsp_p`=15 stable and all `req_ready`=0.
  - Release: drain and new accept occur in the same cycle.
- **Non-power-of-two and skip:** `N_REQ`=3, only requesters 0 and 2 valid.
  - Expect grants alternate 0,2,0,2 and the pointer never exceeds 2.
- **Exhaustive products and counter wrap:**
  - All 64 A/B pairs through requester 1 produce the exact product.
  - Preload to 65535 transfers, then one more: `txn_count` wraps to 0.
